// File: rtl/result_display_if.sv
// result_display_if: game-state/result bus between the reaction game core and the result display.
// The master side drives the game state and tick count; the slave side (the display) returns
// segment/anode drive, the converted millisecond result and its busy flag.
interface result_display_if;
    logic [2:0]  i_state;
    logic [27:0] i_ticks;
    logic [6:0]  o_seg;
    logic [3:0]  o_an;
    logic [13:0] o_ms;
    logic        o_busy;

    modport master (
        output i_state, i_ticks,
        input  o_seg, o_an, o_ms, o_busy
    );

    modport slave (
        input  i_state, i_ticks,
        output o_seg, o_an, o_ms, o_busy
    );
endinterface

// File: rtl/result_display.sv
// result_display: converts a VALID reaction time (20 ns ticks) to ms and drives a 4-digit 7-segment display.
// Ticks are divided by 50,000 with one subtraction per cycle (saturating at 9999), then turned into
// BCD with a 14-cycle double-dabble. Digits are multiplexed every P_REFRESH_CYCLES clocks.
// Optional feature: define RESULT_DISPLAY_BEST_SCORE_EN to keep the best (minimum) result since
// reset and show it while the game is IDLE.
module result_display #(
    parameter int unsigned P_REFRESH_CYCLES = 50000
) (
    input  logic            i_clk_50m,
    input  logic            i_rst,
    result_display_if.slave bus
);
    localparam logic [2:0]  ST_IDLE  = 3'b000;
    localparam logic [2:0]  ST_ARMED = 3'b001;
    localparam logic [2:0]  ST_LIT   = 3'b010;
    localparam logic [2:0]  ST_LATE  = 3'b011;
    localparam logic [2:0]  ST_EARLY = 3'b110;
    localparam logic [2:0]  ST_VALID = 3'b100;

    localparam logic [27:0] TICKS_PER_MS = 28'd50000;
    localparam logic [13:0] MS_MAX       = 14'd9999;

    localparam int          RW           = $clog2(P_REFRESH_CYCLES);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(P_REFRESH_CYCLES - 1);

    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;
    localparam logic [6:0]  SEG_EIGHT = 7'b0000000;
    localparam logic [6:0]  SEG_E     = 7'b0000110;
    localparam logic [6:0]  SEG_R     = 7'b0101111;
    localparam logic [6:0]  SEG_L     = 7'b1000111;
    localparam logic [6:0]  SEG_A     = 7'b0001000;
    localparam logic [6:0]  SEG_T     = 7'b0000111;

    typedef enum logic [1:0] {S_WAIT, S_DIV, S_BCD} conv_t;

    conv_t       r_conv;
    logic [2:0]  r_state;
    logic [27:0] r_rem;
    logic [13:0] r_q;
    logic [29:0] r_dd;
    logic [3:0]  r_step;
    logic [15:0] r_bcd;
    logic [13:0] r_ms;
    logic        r_busy;
    logic [RW-1:0] r_refresh;
    logic [1:0]  r_digit;
    logic [6:0]  r_seg;
    logic [3:0]  r_an;

    logic        w_start;
    logic        w_done;
    logic [29:0] w_dd_adj;
    logic [29:0] w_dd_next;
    logic [6:0]  w_seg;

`ifdef RESULT_DISPLAY_BEST_SCORE_EN
    logic [13:0] r_best;
    logic [15:0] r_best_bcd;
    logic        r_best_vld;
`endif

    // Active-low pattern for one decimal digit.
    function automatic logic [6:0] f_hex(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Glyph for digit d of a 4-digit BCD number; leading zeros blank, the units digit is always shown.
    function automatic logic [6:0] f_number(input logic [15:0] bcd, input logic [1:0] d);
        logic lead;
        lead = (d == 2'd3) ? (bcd[15:12] == 4'd0) :
               (d == 2'd2) ? (bcd[15:8]  == 8'd0) :
               (d == 2'd1) ? (bcd[15:4]  == 12'd0) : 1'b0;
        return lead ? SEG_BLANK : f_hex(bcd[{d, 2'b00} +: 4]);
    endfunction

    // A start is a fresh VALID edge seen only while no conversion is running.
    assign w_start = (bus.i_state == ST_VALID) && (r_state != ST_VALID) && (r_conv == S_WAIT);
    assign w_done  = (r_conv == S_BCD) && (r_step == 4'd13);

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift the whole register left.
    always_comb begin
        w_dd_adj = r_dd;
        for (int k = 0; k < 4; k++)
            if (r_dd[14 + 4*k +: 4] >= 4'd5) w_dd_adj[14 + 4*k +: 4] = r_dd[14 + 4*k +: 4] + 4'd3;
        w_dd_next = w_dd_adj << 1;
    end

    // Previous game state, used to detect the VALID entry edge.
    always_ff @(posedge i_clk_50m) begin
        r_state <= i_rst ? ST_IDLE : bus.i_state;
    end

    // Conversion FSM: WAIT -> DIV (repeated subtraction) -> BCD (14 shifts) -> WAIT.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_conv <= S_WAIT;
            r_busy <= 1'b0;
            r_rem  <= '0;
            r_q    <= '0;
            r_dd   <= '0;
            r_step <= '0;
            r_bcd  <= '0;
            r_ms   <= '0;
        end else begin
            case (r_conv)
                S_WAIT: if (w_start) begin
                    r_rem  <= bus.i_ticks;
                    r_q    <= '0;
                    r_busy <= 1'b1;
                    r_conv <= S_DIV;
                end
                S_DIV: if (r_rem >= TICKS_PER_MS && r_q < MS_MAX) begin
                    r_rem <= r_rem - TICKS_PER_MS;
                    r_q   <= r_q + 14'd1;
                end else begin
                    r_dd   <= {16'd0, r_q};
                    r_step <= '0;
                    r_conv <= S_BCD;
                end
                S_BCD: begin
                    r_dd   <= w_dd_next;
                    r_step <= r_step + 4'd1;
                    if (w_done) begin
                        r_bcd  <= w_dd_next[29:14];
                        r_ms   <= r_q;
                        r_busy <= 1'b0;
                        r_conv <= S_WAIT;
                    end
                end
                default: r_conv <= S_WAIT;
            endcase
        end
    end

`ifdef RESULT_DISPLAY_BEST_SCORE_EN
    // Best score: smallest completed result since reset, captured together with its BCD digits.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_best     <= '0;
            r_best_bcd <= '0;
            r_best_vld <= 1'b0;
        end else if (w_done && (!r_best_vld || r_q < r_best)) begin
            r_best     <= r_q;
            r_best_bcd <= w_dd_next[29:14];
            r_best_vld <= 1'b1;
        end
    end
`endif

    // Glyph for the active digit, chosen from the live game state.
    always_comb begin
        w_seg = SEG_BLANK;
        case (bus.i_state)
            ST_VALID: w_seg = r_busy ? SEG_DASH : f_number(r_bcd, r_digit);
            ST_LIT:   w_seg = SEG_EIGHT;
            ST_LATE:  w_seg = (r_digit == 2'd3) ? SEG_L : (r_digit == 2'd2) ? SEG_A :
                              (r_digit == 2'd1) ? SEG_T : SEG_E;
            ST_EARLY: w_seg = (r_digit == 2'd3) ? SEG_E : (r_digit == 2'd0) ? SEG_BLANK : SEG_R;
`ifdef RESULT_DISPLAY_BEST_SCORE_EN
            ST_IDLE:  w_seg = r_best_vld ? f_number(r_best_bcd, r_digit) : SEG_DASH;
`else
            ST_IDLE:  w_seg = SEG_DASH;
`endif
            ST_ARMED: w_seg = SEG_BLANK;
            default:  w_seg = SEG_BLANK;
        endcase
    end

    // Digit multiplexing; segments and anodes are registered together so they switch on the same edge.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_refresh <= '0;
            r_digit   <= '0;
            r_seg     <= SEG_BLANK;
            r_an      <= 4'b1111;
        end else begin
            r_refresh <= (r_refresh == REFRESH_LAST) ? '0 : r_refresh + 1'b1;
            if (r_refresh == REFRESH_LAST) r_digit <= r_digit + 2'd1;
            r_seg <= w_seg;
            r_an  <= ~(4'b0001 << r_digit);
        end
    end

    assign bus.o_seg  = r_seg;
    assign bus.o_an   = r_an;
    assign bus.o_ms   = r_ms;
    assign bus.o_busy = r_busy;
endmodule

// File: tb/tb_result_display.sv
// tb_result_display: randomized self-checking bench for result_display against a decimal reference model.
// Honours RESULT_DISPLAY_BEST_SCORE_EN for the IDLE best-score expectation.
module tb_result_display;
    localparam int R = 20;
    localparam logic [2:0] IDLE = 3'b000, ARMED = 3'b001, LIT = 3'b010, LATE = 3'b011,
                           VALID = 3'b100, EARLY = 3'b110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   best_ms = 0;
    bit   best_vld = 0;

    result_display_if bus();
    result_display_if bus_full();

    result_display #(.P_REFRESH_CYCLES(R)) dut (.i_clk_50m(clk), .i_rst(rst), .bus(bus));
    result_display dut_full (.i_clk_50m(clk), .i_rst(rst), .bus(bus_full));

    always #10 clk = ~clk;

    // Reference: whole milliseconds, saturated at 9999.
    function automatic int ref_ms(longint t);
        longint q;
        q = t / 50000;
        return (q > 9999) ? 9999 : int'(q);
    endfunction

    function automatic logic [6:0] glyph(byte c);
        case (c)
            "0": return 7'b1000000;
            "1": return 7'b1111001;
            "2": return 7'b0100100;
            "3": return 7'b0110000;
            "4": return 7'b0011001;
            "5": return 7'b0010010;
            "6": return 7'b0000010;
            "7": return 7'b1111000;
            "8": return 7'b0000000;
            "9": return 7'b0010000;
            "-": return 7'b0111111;
            " ": return 7'b1111111;
            "E": return 7'b0000110;
            "r": return 7'b0101111;
            "L": return 7'b1000111;
            "A": return 7'b0001000;
            "t": return 7'b0000111;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    // Leftmost character is digit 3.
    function automatic logic [27:0] disp(string s);
        return {glyph(s[0]), glyph(s[1]), glyph(s[2]), glyph(s[3])};
    endfunction

    function automatic string num_str(int v);
        return $sformatf("%4d", v);
    endfunction

    function automatic string idle_str();
`ifdef RESULT_DISPLAY_BEST_SCORE_EN
        return best_vld ? num_str(best_ms) : "----";
`else
        return "----";
`endif
    endfunction

    function automatic void note_result(int ms);
        if (!best_vld || ms < best_ms) best_ms = ms;
        best_vld = 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        best_vld = 0;
    endtask

    // Collect the glyph shown at each anode position over a full multiplex cycle.
    task automatic grab(output logic [27:0] got, output bit an_ok);
        got = 'x;
        an_ok = 1;
        for (int i = 0; i < 4*R + 4; i++) begin
            step();
            case (bus.o_an)
                4'b1110: got[6:0]   = bus.o_seg;
                4'b1101: got[13:7]  = bus.o_seg;
                4'b1011: got[20:14] = bus.o_seg;
                4'b0111: got[27:21] = bus.o_seg;
                default: an_ok = 0;
            endcase
        end
    endtask

    // Launch one conversion from a non-VALID state; report busy length and o_ms seen on the last busy cycle.
    task automatic run_conv(input logic [27:0] ticks, output int len, output int ms_last_busy);
        bus.i_state = ARMED;
        step();
        bus.i_ticks = ticks;
        bus.i_state = VALID;
        len = 0;
        ms_last_busy = -1;
        step();
        while (bus.o_busy === 1'b1 && len < 12000) begin
            ms_last_busy = int'(bus.o_ms);
            len++;
            step();
        end
        note_result(ref_ms(longint'(ticks)));
    endtask

    task automatic check_conv(string name, logic [27:0] ticks, bit check_disp);
        int len, mlb, exp_ms, prev_ms;
        logic [27:0] got;
        bit ok;
        prev_ms = int'(bus.o_ms);
        exp_ms = ref_ms(longint'(ticks));
        run_conv(ticks, len, mlb);
        n_vec++;
        if (len !== exp_ms + 15) begin
            n_err++;
            $display("FAIL %s busy_len: got %0d want %0d", name, len, exp_ms + 15);
        end
        n_vec++;
        if (int'(bus.o_ms) !== exp_ms) begin
            n_err++;
            $display("FAIL %s o_ms: got %0d want %0d", name, bus.o_ms, exp_ms);
        end
        n_vec++;
        if (mlb !== prev_ms) begin
            n_err++;
            $display("FAIL %s o_ms_before_fall: got %0d want %0d", name, mlb, prev_ms);
        end
        if (check_disp) begin
            grab(got, ok);
            n_vec++;
            if (got !== disp(num_str(exp_ms)) || !ok) begin
                n_err++;
                $display("FAIL %s display: got %h want %h an_ok %0d", name, got, disp(num_str(exp_ms)), ok);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_state = IDLE;
        bus.i_ticks = '0;
        repeat (3) step();
        n_vec++;
        if (bus.o_seg !== 7'b1111111) begin n_err++; $display("FAIL reset o_seg: got %b want 1111111", bus.o_seg); end
        n_vec++;
        if (bus.o_an !== 4'b1111) begin n_err++; $display("FAIL reset o_an: got %b want 1111", bus.o_an); end
        n_vec++;
        if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL reset o_busy: got %b want 0", bus.o_busy); end
        n_vec++;
        if (bus.o_ms !== 14'd0) begin n_err++; $display("FAIL reset o_ms: got %0d want 0", bus.o_ms); end
        rst = 1'b0;
        best_vld = 0;
    endtask

    task automatic test_spec_vector();
        check_conv("ticks_12345678", 28'd12345678, 1);
    endtask

    task automatic test_boundaries();
        check_conv("ticks_49999", 28'd49999, 1);
        check_conv("ticks_50000", 28'd50000, 1);
        check_conv("ticks_max", 28'd268435455, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++)
            check_conv($sformatf("rand_%0d", i), 28'($urandom_range(0, 15000000)), (i % 3) == 0);
    endtask

    task automatic test_glyphs();
        logic [2:0] st [6] = '{LIT, LATE, EARLY, ARMED, 3'b101, 3'b111};
        string      ex [6] = '{"8888", "LAtE", "Err ", "    ", "    ", "    "};
        logic [27:0] got;
        logic [27:0] ticks;
        bit ok;
        int cnt, q;
        for (int i = 0; i < 6; i++) begin
            int j;
            j = $urandom_range(0, 5);
            bus.i_state = st[j];
            grab(got, ok);
            n_vec++;
            if (got !== disp(ex[j]) || !ok) begin
                n_err++;
                $display("FAIL glyph_state_%b: got %h want %h an_ok %0d", st[j], got, disp(ex[j]), ok);
            end
        end
        bus.i_state = IDLE;
        grab(got, ok);
        n_vec++;
        if (got !== disp(idle_str()) || !ok) begin
            n_err++;
            $display("FAIL glyph_idle: got %h want %h an_ok %0d", got, disp(idle_str()), ok);
        end
        q = $urandom_range(1000, 1500);
        ticks = 28'(q * 50000 + $urandom_range(0, 49999));
        bus.i_state = ARMED;
        step();
        bus.i_ticks = ticks;
        bus.i_state = VALID;
        step();
        grab(got, ok);
        n_vec++;
        if (got !== disp("----") || !ok) begin
            n_err++;
            $display("FAIL glyph_busy: got %h want %h an_ok %0d", got, disp("----"), ok);
        end
        cnt = 0;
        while (bus.o_busy === 1'b1 && cnt < 12000) begin cnt++; step(); end
        note_result(q);
        grab(got, ok);
        n_vec++;
        if (got !== disp(num_str(q)) || !ok) begin
            n_err++;
            $display("FAIL glyph_result: got %h want %h an_ok %0d", got, disp(num_str(q)), ok);
        end
    endtask

    // Re-triggers and leaving VALID mid-conversion must not disturb the running conversion.
    task automatic test_back_to_back();
        int qa, len;
        qa = $urandom_range(20, 60);
        bus.i_state = ARMED;
        step();
        bus.i_ticks = 28'(qa * 50000 + $urandom_range(0, 49999));
        bus.i_state = VALID;
        len = 0;
        step();
        while (bus.o_busy === 1'b1 && len < 12000) begin
            len++;
            if (len == 5) bus.i_state = ARMED;
            if (len == 7) begin bus.i_state = VALID; bus.i_ticks = 28'($urandom_range(3000000, 4000000)); end
            if (len == 9) bus.i_state = LIT;
            step();
        end
        note_result(qa);
        n_vec++;
        if (len !== qa + 15) begin n_err++; $display("FAIL b2b busy_len: got %0d want %0d", len, qa + 15); end
        n_vec++;
        if (int'(bus.o_ms) !== qa) begin n_err++; $display("FAIL b2b o_ms: got %0d want %0d", bus.o_ms, qa); end
        repeat (3) step();
        n_vec++;
        if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL b2b idle_after: got %b want 0", bus.o_busy); end
    endtask

    task automatic test_best();
        logic [27:0] got;
        bit ok;
        bus.i_state = IDLE;
        do_reset();
        check_conv("best_300", 28'd15000000, 0);
        check_conv("best_250", 28'd12500000, 0);
        check_conv("best_400", 28'd20000000, 0);
        bus.i_state = IDLE;
        grab(got, ok);
        n_vec++;
        if (got !== disp(idle_str()) || !ok) begin
            n_err++;
            $display("FAIL best_idle: got %h want %h an_ok %0d", got, disp(idle_str()), ok);
        end
    endtask

    task automatic test_reset_abort();
        int cnt;
        bus.i_state = ARMED;
        step();
        bus.i_ticks = 28'd50000000;
        bus.i_state = VALID;
        step();
        cnt = 0;
        while (bus.o_busy === 1'b1 && cnt < 100) begin cnt++; step(); end
        n_vec++;
        if (cnt !== 100) begin n_err++; $display("FAIL abort busy_before: got %0d want 100", cnt); end
        rst = 1'b1;
        bus.i_state = ARMED;
        step();
        n_vec++;
        if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL abort o_busy: got %b want 0", bus.o_busy); end
        n_vec++;
        if (bus.o_ms !== 14'd0) begin n_err++; $display("FAIL abort o_ms: got %0d want 0", bus.o_ms); end
        rst = 1'b0;
        best_vld = 0;
        repeat (1100) step();
        n_vec++;
        if (bus.o_ms !== 14'd0 || bus.o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort later: got ms %0d busy %b want ms 0 busy 0", bus.o_ms, bus.o_busy);
        end
    endtask

    task automatic test_reset_start();
        int len;
        rst = 1'b1;
        bus.i_state = VALID;
        bus.i_ticks = 28'd100000;
        step();
        rst = 1'b0;
        best_vld = 0;
        len = 0;
        step();
        while (bus.o_busy === 1'b1 && len < 12000) begin len++; step(); end
        note_result(2);
        n_vec++;
        if (len !== 17) begin n_err++; $display("FAIL reset_start busy_len: got %0d want 17", len); end
        n_vec++;
        if (bus.o_ms !== 14'd2) begin n_err++; $display("FAIL reset_start o_ms: got %0d want 2", bus.o_ms); end
    endtask

    // Anode walk: short-period DUT over more than one full rotation, default DUT at its first 50,000-cycle boundary.
    task automatic test_refresh();
        int bad;
        logic [3:0] exp_an;
        bus.i_state = IDLE;
        do_reset();
        bad = 0;
        for (int k = 1; k <= 50001; k++) begin
            step();
            if (k <= 5*R) begin
                exp_an = ~(4'b0001 << (((k - 1) / R) % 4));
                if (bus.o_an !== exp_an) bad++;
            end
            if (k == 1 || k == 50000 || k == 50001) begin
                exp_an = ~(4'b0001 << (((k - 1) / 50000) % 4));
                n_vec++;
                if (bus_full.o_an !== exp_an) begin
                    n_err++;
                    $display("FAIL refresh_full_k%0d: got %b want %b", k, bus_full.o_an, exp_an);
                end
            end
        end
        n_vec++;
        if (bad !== 0) begin n_err++; $display("FAIL refresh_walk: got %0d bad samples want 0", bad); end
        n_vec++;
        if (bus_full.o_seg !== glyph("-")) begin
            n_err++;
            $display("FAIL refresh_full_seg: got %b want %b", bus_full.o_seg, glyph("-"));
        end
    endtask

    initial begin
        bus.i_state = IDLE;
        bus.i_ticks = '0;
        bus_full.i_state = IDLE;
        bus_full.i_ticks = '0;
        test_reset();
        test_spec_vector();
        test_boundaries();
        test_random();
        test_glyphs();
        test_back_to_back();
        test_best();
        test_reset_abort();
        test_reset_start();
        test_refresh();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
